// File: rtl/sprite_rom_row_arbiter.sv
// Sprite ROM row arbiter: shares one single-port sprite ROM between the VGA
// renderer (requester 0) and the CPU readback/collision unit (requester 1).
// Each accepted request streams one sprite row, SPR_W words, tagged with the
// owning requester id and column. Requester 1 is guaranteed a grant after at
// most MAX_SKIP consecutive requester-0 grants.
module sprite_rom_row_arbiter #(
  parameter int SPR_W    = 20,
  parameter int SPR_H    = 20,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int MAX_SKIP = 2
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [1:0]        req_valid,
  input  logic [9:0]        req_row,
  output logic [1:0]        req_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_id,
  output logic [4:0]        rd_col,
  output logic              rd_last,
  output logic              err,
  output logic              busy
);

  localparam int                SKIP_W     = $clog2(MAX_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX   = SKIP_W'(MAX_SKIP);
  localparam logic [4:0]        LAST_COL   = 5'(SPR_W - 1);
  localparam logic [4:0]        ROW_LIMIT  = 5'(SPR_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SPR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [4:0]          col_q,      col_d;
  logic                id_q,       id_d;
  logic [SKIP_W-1:0]   skip_q,     skip_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_id_q,    rd_id_d;
  logic [4:0]          rd_col_q,   rd_col_d;
  logic                rd_last_q,  rd_last_d;
  logic                err_q,      err_d;

  logic                gnt_valid;
  logic                gnt_id;
  logic [4:0]          gnt_row;
  logic                gnt_oor;

  // Arbitration: requester 1 wins when alone or once requester 0 has used up its skips.
  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == IDLE) begin
      if (req_valid[1] && (!req_valid[0] || skip_q == SKIP_MAX)) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end else if (req_valid[0]) begin
        gnt_valid = 1'b1;
      end
    end
  end

  assign gnt_row   = gnt_id ? req_row[9:5] : req_row[4:0];
  assign gnt_oor   = (gnt_row >= ROW_LIMIT);
  assign req_ready = {gnt_valid & gnt_id, gnt_valid & ~gnt_id};

  // Next-state logic: burst sequencing, issue-stage tagging and fairness counter.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    col_d      = col_q;
    id_d       = id_q;
    skip_d     = skip_q;
    rd_valid_d = 1'b0;
    rd_id_d    = rd_id_q;
    rd_col_d   = rd_col_q;
    rd_last_d  = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt_oor) begin
            // Bad rows are consumed but flagged; the ROM address is left alone.
            err_d = 1'b1;
          end else begin
            id_d       = gnt_id;
            rom_addr_d = ADDR_W'(gnt_row) * ROW_STRIDE;
            col_d      = 5'd0;
            state_d    = BURST;
          end
        end
      end
      BURST: begin
        // The word addressed this cycle returns next cycle, so its tags are registered now.
        rd_valid_d = 1'b1;
        rd_id_d    = id_q;
        rd_col_d   = col_q;
        rd_last_d  = (col_q == LAST_COL);
        if (col_q == LAST_COL) begin
          state_d = DRAIN;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          col_d      = col_q + 5'd1;
        end
      end
      DRAIN: begin
        // Final word is on the output this cycle; nothing more to issue.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!req_valid[1]) begin
      skip_d = '0;
    end else if (gnt_valid && gnt_id) begin
      skip_d = '0;
    end else if (gnt_valid && !gnt_id && skip_q != SKIP_MAX) begin
      skip_d = skip_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset that overrides any burst.
  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      col_q      <= '0;
      id_q       <= 1'b0;
      skip_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_col_q   <= '0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      id_q       <= id_d;
      skip_q     <= skip_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_col_q   <= rd_col_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rom_data;
  assign rd_id    = rd_id_q;
  assign rd_col   = rd_col_q;
  assign rd_last  = rd_last_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/sprite_rom_row_arbiter.md
Name: sprite_rom_row_arbiter

Overview:
- Shares one single-port, 400x16 sprite ROM (20x20 pixels, 16-bit colour, unregistered output) between two requesters.
- Requester 0 is the VGA sprite renderer. Requester 1 is the CPU/AHB sprite readback or collision unit.
- Each accepted request is one sprite row. The block streams that row's SPR_W words from the ROM, tagged with requester id and column.
- Sits between the requesters and the ROM's addra/doa pins. It is the only driver of the ROM address.

Parameters:
- SPR_W, 20, words per sprite row.
- SPR_H, 20, rows per sprite. SPR_W*SPR_H must be <= 2^ADDR_W.
- ADDR_W, 9, ROM address width.
- DATA_W, 16, ROM data width.
- MAX_SKIP, 2, consecutive requester-0 grants allowed while requester 1 waits.

Ports:
- clka  in  1  clock, shared with the ROM.
- rsta  in  1  synchronous active-high reset.
- req_valid  in  2  request valid; bit i belongs to requester i.
- req_row  in  10  row index; bits [5i+4:5i] belong to requester i.
- req_ready  out  2  one-hot accept, combinational, IDLE state only.
- rom_addr  out  ADDR_W  registered ROM address, drives addra.
- rom_data  in  DATA_W  ROM doa.
- rd_valid  out  1  registered; rd_data is valid this cycle.
- rd_data  out  DATA_W  rom_data passed through combinationally.
- rd_id  out  1  registered; requester owning rd_data.
- rd_col  out  5  registered; column of rd_data (0..SPR_W-1).
- rd_last  out  1  registered; high with rd_valid on column SPR_W-1.
- err  out  1  registered; one-cycle pulse for an out-of-range row.
- busy  out  1  high when state is not IDLE.

Behaviour:
- States: IDLE, BURST, DRAIN.
- Reset: all outputs and registers are 0, state IDLE. rom_addr=0, rd_valid=0, err=0, skip_cnt=0. Reset in any state, including mid-burst, wins.
  - Next cycle: rd_valid=0, busy=0.
  - The partially delivered row is abandoned; no rd_last is emitted.
- Arbitration (IDLE only, evaluated combinationally):
  - Grant requester 1 if req_valid[1] and (!req_valid[0] or skip_cnt==MAX_SKIP). Otherwise grant requester 0 if req_valid[0].
  - req_ready[g]=1 for the granted requester in the grant cycle G. The request is consumed at the end of G.
  - skip_cnt increments on a grant to 0 while req_valid[1]=1. It clears on a grant to 1, or in any cycle with req_valid[1]=0. It saturates at MAX_SKIP.
- Out-of-range request (row >= SPR_H):
  - The request is still accepted (req_ready pulses) and skip_cnt updates normally.
  - err=1 during G+1. No burst runs; state stays IDLE. rom_addr is unchanged.
- Valid grant:
  - At the end of G: latch id; rom_addr <= row*SPR_W (computed at ADDR_W bits); col <= 0; state -> BURST.
  - BURST: during cycle G+1+k, rom_addr = row*SPR_W + k, for k = 0..SPR_W-1. The address increments each cycle.
  - After k = SPR_W-1, state -> DRAIN. rom_addr holds its last value.
  - ROM latency is 1 cycle. Data for address k appears on rom_data during G+2+k.
  - rd_valid, rd_id and rd_col=k are registered from the issue stage, so they are high/valid during G+2+k. rd_last=1 when k = SPR_W-1.
  - DRAIN lasts one cycle (G+SPR_W+1). It carries the final word, then goes to IDLE.
  - No grant is possible before G+SPR_W+2. Minimum request-to-request spacing is SPR_W+2 cycles.
- Request lines are ignored outside IDLE; req_ready=0 there.
- rd_data is undefined when rd_valid=0. There is no backpressure: consumers must accept every rd_valid word.

Test Plan:
- Single request: req0 row 0 accepted at G. rom_addr steps 0..19 in G+1..G+20. rd_valid in G+2..G+21, rd_col 0..19, rd_id=0. rd_last only at G+21. rd_data matches ROM words 0..19.
- Last row: req1 row 19. Addresses 380..399, rd_id=1, rd_last on the word from address 399. busy=1 during G+1..G+21; IDLE and grantable at G+22.
- Simultaneous: both valid at G (rows 3, 7). Requester 0 is granted first (addresses 60..79). Requester 1 is granted at G+22 (addresses 140..159).
- Starvation guard: req0 and req1 held valid continuously, MAX_SKIP=2. Grant sequence is 0,0,1,0,0,1. skip_cnt clears after each grant to 1.
- Out of range: req0 row 20. req_ready[0] pulses, err=1 at G+1, rd_valid stays 0, rom_addr unchanged. A new request is accepted at G+1.
- Reset mid-burst: rsta asserted during the cycle where rom_addr=row*20+7. Next cycle: rom_addr=0, rd_valid=0, busy=0. A subsequent req0 row 1 restarts at address 20, col 0.
